// File: rtl/idct_frame_sequencer_pkg.sv
// Shared definitions for the IDCT frame sequencer and the Full_idct datapath.
// Holds the FSM state encoding and the default pipeline offsets. Keeping them here
// means the datapath and the schedule always agree.
package idct_pkg;

  localparam int ADDR_W    = 15;
  localparam int NUM_ROWS  = 16384;
  localparam int TP1_START = 26;
  localparam int TP2_START = 35;
  localparam int OUT_START = 44;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seqState_t;

endpackage

// File: rtl/idct_frame_sequencer_if.sv
// Control bundle between the frame sequencer, the frame controller, the SRAMs
// and the two transpose memories. The sequencer drives everything except start.
interface idct_frame_sequencer_if #(
  parameter int ADDR_W = idct_pkg::ADDR_W
);

  logic              start;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              tp1_enable;
  logic              tp1_rst_n;
  logic              tp2_enable;
  logic              tp2_rst_n;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;

  modport master (
    input  start,
    output busy, done, rd_en, rd_addr,
    output tp1_enable, tp1_rst_n, tp2_enable, tp2_rst_n,
    output wr_en, wr_addr
  );

  modport slave (
    output start,
    input  busy, done, rd_en, rd_addr,
    input  tp1_enable, tp1_rst_n, tp2_enable, tp2_rst_n,
    input  wr_en, wr_addr
  );

endinterface

// File: rtl/idct_frame_sequencer.sv
// Frame sequencer for the two-pass IDCT. It streams NUM_ROWS coefficient reads,
// arms the transpose memories at fixed offsets, and streams NUM_ROWS output writes
// starting OUT_START cycles after the first read. Completion is reported with a
// one-cycle done pulse. Every output comes straight from a register.
module idct_frame_sequencer #(
  parameter int ADDR_W    = idct_pkg::ADDR_W,
  parameter int NUM_ROWS  = idct_pkg::NUM_ROWS,
  parameter int TP1_START = idct_pkg::TP1_START,
  parameter int TP2_START = idct_pkg::TP2_START,
  parameter int OUT_START = idct_pkg::OUT_START
) (
  input  logic                  clk,
  input  logic                  reset,
  idct_frame_sequencer_if.master bus
);

  import idct_pkg::*;

  localparam int                CYC_W      = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ROW   = ADDR_W'(NUM_ROWS - 1);
  localparam logic [CYC_W-1:0]  CYC_TP1    = CYC_W'(TP1_START);
  localparam logic [CYC_W-1:0]  CYC_TP2    = CYC_W'(TP2_START);
  localparam logic [CYC_W-1:0]  CYC_OUT    = CYC_W'(OUT_START);
  localparam logic [CYC_W-1:0]  CYC_WR_ARM = CYC_W'(OUT_START - 1);

  // Offsets must be strictly ordered and frames must be whole 8x8 blocks.
  if (!(TP1_START >= 0 && TP1_START < TP2_START && TP2_START < OUT_START) ||
      (NUM_ROWS % 8 != 0) || (NUM_ROWS < 8)) begin : g_paramCheck
    $error("idct_frame_sequencer: illegal offsets or NUM_ROWS");
  end

  seqState_t         r_state, w_stateNext;
  logic [CYC_W-1:0]  r_cyc, w_cycNext, w_cycStep;
  logic [ADDR_W-1:0] r_rdAddr, w_rdAddrNext;
  logic [ADDR_W-1:0] r_wrAddr, w_wrAddrNext;
  logic              r_rdEn, w_rdEnNext;
  logic              r_wrEn, w_wrEnNext;
  logic              r_tp1, w_tp1Next;
  logic              r_tp2, w_tp2Next;
  logic              r_busy, w_busyNext;
  logic              r_done, w_doneNext;

  // The cycle counter only matters up to OUT_START, so it parks there.
  assign w_cycStep = (r_cyc == CYC_OUT) ? r_cyc : r_cyc + CYC_W'(1);

  // Next-state and next-output logic; every register holds unless a branch says otherwise.
  always_comb begin
    w_stateNext  = r_state;
    w_cycNext    = r_cyc;
    w_rdEnNext   = r_rdEn;
    w_rdAddrNext = r_rdAddr;
    w_wrEnNext   = r_wrEn;
    w_wrAddrNext = r_wrAddr;
    w_tp1Next    = r_tp1;
    w_tp2Next    = r_tp2;
    w_busyNext   = r_busy;
    w_doneNext   = 1'b0;
    case (r_state)
      IDLE: begin
        w_busyNext = 1'b0;
        w_rdEnNext = 1'b0;
        w_wrEnNext = 1'b0;
        w_tp1Next  = 1'b0;
        w_tp2Next  = 1'b0;
        if (bus.start) begin
          w_stateNext  = RUN;
          w_busyNext   = 1'b1;
          w_cycNext    = '0;
          w_rdEnNext   = 1'b1;
          w_rdAddrNext = '0;
          w_wrAddrNext = '0;
          w_tp1Next    = (TP1_START == 0);
        end
      end
      RUN, DRAIN: begin
        w_cycNext = w_cycStep;
        if (w_cycStep == CYC_TP1) w_tp1Next = 1'b1;
        if (w_cycStep == CYC_TP2) w_tp2Next = 1'b1;
        if (r_state == RUN) begin
          if (r_rdAddr == LAST_ROW) begin
            w_rdEnNext  = 1'b0;
            w_stateNext = DRAIN;
          end else begin
            w_rdAddrNext = r_rdAddr + ADDR_W'(1);
          end
        end
        if (r_wrEn) begin
          if (r_wrAddr == LAST_ROW) begin
            w_wrEnNext  = 1'b0;
            w_doneNext  = 1'b1;
            w_stateNext = DONE;
          end else begin
            w_wrAddrNext = r_wrAddr + ADDR_W'(1);
          end
        end else if (r_cyc == CYC_WR_ARM) begin
          w_wrEnNext = 1'b1;
        end
      end
      DONE: begin
        w_stateNext = IDLE;
        w_busyNext  = 1'b0;
        w_tp1Next   = 1'b0;
        w_tp2Next   = 1'b0;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // State register; a low reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_stateNext;
  end

  // Counter, address and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cyc    <= '0;
      r_rdEn   <= 1'b0;
      r_rdAddr <= '0;
      r_wrEn   <= 1'b0;
      r_wrAddr <= '0;
      r_tp1    <= 1'b0;
      r_tp2    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_cyc    <= w_cycNext;
      r_rdEn   <= w_rdEnNext;
      r_rdAddr <= w_rdAddrNext;
      r_wrEn   <= w_wrEnNext;
      r_wrAddr <= w_wrAddrNext;
      r_tp1    <= w_tp1Next;
      r_tp2    <= w_tp2Next;
      r_busy   <= w_busyNext;
      r_done   <= w_doneNext;
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.rd_en      = r_rdEn;
  assign bus.rd_addr    = r_rdAddr;
  assign bus.tp1_enable = r_tp1;
  assign bus.tp1_rst_n  = r_tp1;
  assign bus.tp2_enable = r_tp2;
  assign bus.tp2_rst_n  = r_tp2;
  assign bus.wr_en      = r_wrEn;
  assign bus.wr_addr    = r_wrAddr;

endmodule

// File: tb/tb_idct_frame_sequencer.sv
// Bench for the IDCT frame sequencer. Two instances (16-row and 64-row frames)
// share clock and reset. Stimulus queues the expected read/write/done events and
// the busy/transpose windows; a monitor on the falling edge compares against them.
module tb_idct_frame_sequencer;

  localparam int AW   = 15;
  localparam int TP1  = 26;
  localparam int TP2  = 35;
  localparam int OUTS = 44;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   edgeCount = 0;
  int   checks    = 0;
  int   errors    = 0;

  // Queue index = dut*3 + kind; kind 0 = read, 1 = write, 2 = done.
  int cycQ[6][$];
  int addrQ[6][$];
  int busyFrom[2] = '{-1, -1};
  int busyTo[2]   = '{-1, -1};
  int tp1From[2]  = '{-1, -1};
  int tp2From[2]  = '{-1, -1};

  idct_frame_sequencer_if #(.ADDR_W(AW)) bus16 ();
  idct_frame_sequencer_if #(.ADDR_W(AW)) bus64 ();

  idct_frame_sequencer #(.ADDR_W(AW), .NUM_ROWS(16), .TP1_START(TP1), .TP2_START(TP2), .OUT_START(OUTS))
    dut16 (.clk(clk), .reset(reset), .bus(bus16.master));
  idct_frame_sequencer #(.ADDR_W(AW), .NUM_ROWS(64), .TP1_START(TP1), .TP2_START(TP2), .OUT_START(OUTS))
    dut64 (.clk(clk), .reset(reset), .bus(bus64.master));

  logic          busyS[2], doneS[2], rdEnS[2], wrEnS[2];
  logic          tp1EnS[2], tp1RstS[2], tp2EnS[2], tp2RstS[2];
  logic [AW-1:0] rdAddrS[2], wrAddrS[2];

  assign busyS[0]   = bus16.busy;       assign busyS[1]   = bus64.busy;
  assign doneS[0]   = bus16.done;       assign doneS[1]   = bus64.done;
  assign rdEnS[0]   = bus16.rd_en;      assign rdEnS[1]   = bus64.rd_en;
  assign wrEnS[0]   = bus16.wr_en;      assign wrEnS[1]   = bus64.wr_en;
  assign tp1EnS[0]  = bus16.tp1_enable; assign tp1EnS[1]  = bus64.tp1_enable;
  assign tp1RstS[0] = bus16.tp1_rst_n;  assign tp1RstS[1] = bus64.tp1_rst_n;
  assign tp2EnS[0]  = bus16.tp2_enable; assign tp2EnS[1]  = bus64.tp2_enable;
  assign tp2RstS[0] = bus16.tp2_rst_n;  assign tp2RstS[1] = bus64.tp2_rst_n;
  assign rdAddrS[0] = bus16.rd_addr;    assign rdAddrS[1] = bus64.rd_addr;
  assign wrAddrS[0] = bus16.wr_addr;    assign wrAddrS[1] = bus64.wr_addr;

  always #5 clk = ~clk;

  // Count rising edges; the monitor reads this on the falling edge.
  always @(posedge clk) edgeCount <= edgeCount + 1;

  function automatic int inWin(int from, int to);
    return (from >= 0 && edgeCount >= from && edgeCount <= to) ? 1 : 0;
  endfunction

  task automatic checkOutput(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d", name, edgeCount, actual, expected);
    end
  endtask

  task automatic checkEvent(int d, int kind, int addr);
    int idx;
    int c;
    int a;
    idx = d * 3 + kind;
    checks++;
    if (cycQ[idx].size() == 0) begin
      errors++;
      $display("[TB] FAIL event dut%0d kind%0d: got unexpected event at edge %0d addr %0d, expected none",
               d, kind, edgeCount, addr);
    end else begin
      c = cycQ[idx].pop_front();
      a = addrQ[idx].pop_front();
      if (c != edgeCount || a != addr) begin
        errors++;
        $display("[TB] FAIL event dut%0d kind%0d: got edge %0d addr %0d, expected edge %0d addr %0d",
                 d, kind, edgeCount, addr, c, a);
      end
    end
  endtask

  // Scoreboard monitor: level windows every cycle, queued events whenever a strobe is up.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("busy%0d", d), int'(busyS[d]), inWin(busyFrom[d], busyTo[d]));
      checkOutput($sformatf("tp1en%0d", d), int'(tp1EnS[d]), inWin(tp1From[d], busyTo[d]));
      checkOutput($sformatf("tp1rstn%0d", d), int'(tp1RstS[d]), inWin(tp1From[d], busyTo[d]));
      checkOutput($sformatf("tp2en%0d", d), int'(tp2EnS[d]), inWin(tp2From[d], busyTo[d]));
      checkOutput($sformatf("tp2rstn%0d", d), int'(tp2RstS[d]), inWin(tp2From[d], busyTo[d]));
      if (rdEnS[d]) checkEvent(d, 0, int'(rdAddrS[d]));
      if (wrEnS[d]) checkEvent(d, 1, int'(wrAddrS[d]));
      if (doneS[d]) checkEvent(d, 2, 0);
    end
  end

  // Pulse start for one cycle; when it should be accepted, queue the whole frame.
  task automatic applyStimulus(int d, bit accept);
    int t;
    int n;
    t = edgeCount + 1;
    n = (d == 0) ? 16 : 64;
    if (d == 0) bus16.start = 1'b1;
    else        bus64.start = 1'b1;
    if (accept) begin
      busyFrom[d] = t;
      busyTo[d]   = t + OUTS + n;
      tp1From[d]  = t + TP1;
      tp2From[d]  = t + TP2;
      for (int k = 0; k < n; k++) begin
        cycQ[d*3].push_back(t + k);
        addrQ[d*3].push_back(k);
        cycQ[d*3+1].push_back(t + OUTS + k);
        addrQ[d*3+1].push_back(k);
      end
      cycQ[d*3+2].push_back(t + OUTS + n);
      addrQ[d*3+2].push_back(0);
    end
    @(negedge clk);
    if (d == 0) bus16.start = 1'b0;
    else        bus64.start = 1'b0;
  endtask

  task automatic waitUntil(int e);
    while (edgeCount < e) @(negedge clk);
  endtask

  task automatic checkIdle(string tag);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("%s_busy%0d", tag, d), int'(busyS[d]), 0);
      checkOutput($sformatf("%s_done%0d", tag, d), int'(doneS[d]), 0);
      checkOutput($sformatf("%s_rden%0d", tag, d), int'(rdEnS[d]), 0);
      checkOutput($sformatf("%s_rdaddr%0d", tag, d), int'(rdAddrS[d]), 0);
      checkOutput($sformatf("%s_tp1en%0d", tag, d), int'(tp1EnS[d]), 0);
      checkOutput($sformatf("%s_tp1rstn%0d", tag, d), int'(tp1RstS[d]), 0);
      checkOutput($sformatf("%s_tp2en%0d", tag, d), int'(tp2EnS[d]), 0);
      checkOutput($sformatf("%s_tp2rstn%0d", tag, d), int'(tp2RstS[d]), 0);
      checkOutput($sformatf("%s_wren%0d", tag, d), int'(wrEnS[d]), 0);
      checkOutput($sformatf("%s_wraddr%0d", tag, d), int'(wrAddrS[d]), 0);
    end
  endtask

  initial begin
    int t;
    int t2;
    int t3;
    int t4;
    int t5;
    bus16.start = 1'b0;
    bus64.start = 1'b0;
    reset = 1'b0;

    // Three reset edges, then a long idle stretch with no start.
    waitUntil(3);
    reset = 1'b1;
    waitUntil(4);
    checkIdle("reset");
    waitUntil(54);

    // 16-row frame with ignored starts during busy and coincident with done.
    t = edgeCount + 1;
    applyStimulus(0, 1'b1);
    waitUntil(t + 4);
    applyStimulus(0, 1'b0);
    waitUntil(t + 29);
    applyStimulus(0, 1'b0);
    waitUntil(t + 60);
    checkOutput("doneCoincident", int'(doneS[0]), 1);
    applyStimulus(0, 1'b0);

    // Back-to-back frame accepted in the first idle cycle after done.
    t2 = edgeCount + 1;
    checkOutput("restartEdge", t2, t + 62);
    applyStimulus(0, 1'b1);
    waitUntil(t2 + 44);
    checkOutput("wrRestartEn", int'(wrEnS[0]), 1);
    checkOutput("wrRestartAddr", int'(wrAddrS[0]), 0);
    waitUntil(t2 + 62);

    // Reset in the middle of a frame, then a clean rerun.
    t3 = edgeCount + 1;
    applyStimulus(0, 1'b1);
    waitUntil(t3 + 19);
    reset = 1'b0;
    busyTo[0] = edgeCount;
    for (int i = 0; i < 6; i++) begin
      cycQ[i].delete();
      addrQ[i].delete();
    end
    waitUntil(t3 + 20);
    checkIdle("midReset");
    reset = 1'b1;
    t4 = edgeCount + 1;
    applyStimulus(0, 1'b1);
    waitUntil(t4 + 62);

    // 64-row frame: writes begin while reads are still in flight.
    t5 = edgeCount + 1;
    applyStimulus(1, 1'b1);
    waitUntil(t5 + 44);
    checkOutput("overlapRdEn", int'(rdEnS[1]), 1);
    checkOutput("overlapRdAddr", int'(rdAddrS[1]), 44);
    checkOutput("overlapWrEn", int'(wrEnS[1]), 1);
    checkOutput("overlapWrAddr", int'(wrAddrS[1]), 0);
    waitUntil(t5 + 64 + 44 + 3);

    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("pendingEvents%0d", i), cycQ[i].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so a stuck run still terminates.
  initial begin
    #50000;
    $display("[TB] FAIL watchdog: got timeout at edge %0d, expected completion", edgeCount);
    $fatal(1, "[TB] timeout");
  end

endmodule
